pll_lock_supervisor: RTL and testbench

Sequences the 50 MHz→100 MHz system PLL and generates the system reset for all logic it clocks. The block runs on the free-running reference clock and drives the PLL reset input. It qualifies the PLL's lock indication before releasing the system reset. It retries the PLL on lock timeout and re-sequences it on loss of lock. It sits at the top level, between the board clock/reset pins, the PLL wrapper and the core's reset tree.

---
 rtl/pll_lock_supervisor_if.sv | 34 +++
 rtl/pll_lock_supervisor.sv | 152 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings
// (PLL wrapper, reset tree, debug/status consumers).
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_fail;
    logic [7:0] loss_count;
    logic [2:0] state_dbg;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output lock_fail,
        output loss_count,
        output state_dbg
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  lock_fail,
        input  loss_count,
        input  state_dbg
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the system PLL from the free-running reference clock: pulses its reset,
// qualifies lock, releases the system reset and retries or re-sequences on failure.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_supervisor_if.master bus
);
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // pll_locked comes from the PLL's own domain; only the synchronised copy is used
    logic [SYNC_STAGES:0] sync_chain;
    logic                 locked_s;

    assign sync_chain[0] = bus.pll_locked;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            always_ff @(posedge refclk) begin
                if (rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= sync_chain[gi];
                end
            end
            assign sync_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign locked_s = sync_chain[SYNC_STAGES];

    state_t         state_reg, state_next;
    logic [CW-1:0]  counter_reg, counter_next;
    logic [7:0]     retry_reg, retry_next;
    logic [7:0]     loss_reg, loss_next;
    logic           pll_rst_reg, sys_rst_reg, ready_reg, lock_fail_reg;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg + CW'(1);
        retry_next   = retry_reg;
        loss_next    = loss_reg;

        if (bus.relock_req) begin
            state_next   = RESET_PLL;
            counter_next = '0;
            retry_next   = '0;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (counter_reg == RST_LAST) begin
                        state_next   = WAIT_LOCK;
                        counter_next = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next   = STABLE;
                        counter_next = '0;
                    end else if (counter_reg == TIMEOUT_LAST) begin
                        counter_next = '0;
                        if (retry_reg == RETRY_LIMIT) begin
                            state_next = FAIL;
                        end else begin
                            state_next = RESET_PLL;
                            retry_next = retry_reg + 8'd1;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_next   = WAIT_LOCK;
                        counter_next = '0;
                    end else if (counter_reg == STABLE_LAST) begin
                        state_next   = RUN;
                        counter_next = '0;
                        retry_next   = '0;
                    end
                end
                RUN: begin
                    // Counter is parked in the open-ended states so it can never wrap
                    counter_next = '0;
                    if (!locked_s) begin
                        state_next = RESET_PLL;
                        if (loss_reg != 8'hFF) begin
                            loss_next = loss_reg + 8'd1;
                        end
                    end
                end
                FAIL: begin
                    counter_next = '0;
                end
                default: begin
                    state_next   = RESET_PLL;
                    counter_next = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_reg
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg     <= RESET_PLL;
            counter_reg   <= '0;
            retry_reg     <= '0;
            loss_reg      <= '0;
            pll_rst_reg   <= 1'b1;
            sys_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            lock_fail_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAIL);
            sys_rst_reg   <= (state_next != RUN);
            ready_reg     <= (state_next == RUN);
            lock_fail_reg <= (state_next == FAIL);
        end
    end

    assign bus.pll_rst    = pll_rst_reg;
    assign bus.sys_rst    = sys_rst_reg;
    assign bus.ready      = ready_reg;
    assign bus.lock_fail  = lock_fail_reg;
    assign bus.loss_count = loss_reg;
    assign bus.state_dbg  = state_reg;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small cycle parameters
// so every scenario finishes in a few thousand reference clock cycles.
module tb_pll_lock_supervisor;
    localparam int P_RST     = 4;
    localparam int P_TIMEOUT = 32;
    localparam int P_STABLE  = 8;
    localparam int P_RETRIES = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TIMEOUT),
        .STABLE_CYCLES  (P_STABLE),
        .MAX_RETRIES    (P_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs sampled 1 ns after it, inputs applied for the next edge
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int limit, output int n);
        n = 0;
        while (bus.state_dbg !== tgt && n < limit) begin
            step();
            n++;
        end
        if (bus.state_dbg !== tgt) n = -1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    int n;
    int first_stable, first_run;
    int saw_ready, saw_pll_rst;
    logic exp_rst;

    initial begin
        // Scenario 1: basic lock
        do_reset();
        check("reset_state", bus.state_dbg, 0);
        check("reset_pll_rst", bus.pll_rst, 1);
        check("reset_sys_rst", bus.sys_rst, 1);
        check("reset_ready", bus.ready, 0);
        check("reset_lock_fail", bus.lock_fail, 0);
        check("reset_loss_count", bus.loss_count, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("basic_pll_rst_high", bus.pll_rst, 1);
        end
        step();
        check("basic_pll_rst_released", bus.pll_rst, 0);
        check("basic_state_wait", bus.state_dbg, 1);
        repeat (6) step();
        bus.pll_locked = 1'b1;
        first_stable = 0;
        first_run    = 0;
        for (int k = 1; k <= 20 && first_run == 0; k++) begin
            step();
            if (bus.state_dbg == 3'd2 && first_stable == 0) first_stable = k;
            if (bus.state_dbg == 3'd3) first_run = k;
        end
        check("basic_stable_latency", first_stable, 3);
        check("basic_run_latency", first_run, 11);
        check("basic_ready", bus.ready, 1);
        check("basic_sys_rst", bus.sys_rst, 0);
        $display("scenario basic_lock: run after %0d cycles", first_run);

        // Scenario 4: 300 losses in RUN, loss_count saturates
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b0;
            step();
            step();
            if (i < 2) check("loss_ready_still_high", bus.ready, 1);
            step();
            check("loss_sys_rst", bus.sys_rst, 1);
            check("loss_ready_low", bus.ready, 0);
            check("loss_count", bus.loss_count, (i + 1 > 255) ? 255 : i + 1);
            if (i == 299) break;
            bus.pll_locked = 1'b1;
            if (i < 2) begin
                check("loss_pll_rst_pulse", bus.pll_rst, 1);
                repeat (3) step();
                check("loss_pll_rst_pulse_end", bus.pll_rst, 1);
                step();
                check("loss_pll_rst_released", bus.pll_rst, 0);
            end
            wait_state(3'd3, 60, n);
            if (n < 0) check("loss_relock_timeout", 0, 1);
        end
        $display("scenario loss_in_run: loss_count=%0d", bus.loss_count);

        // Scenario 3: never locks (continuing from the last loss, retry count clear)
        for (int c = 0; c < 116; c++) begin
            exp_rst = (c >= 108) || ((c % 36) < 4);
            check($sformatf("never_lock_pll_rst_c%0d", c), bus.pll_rst, exp_rst);
            if (c == 107) check("never_lock_fail_pre", bus.lock_fail, 0);
            if (c == 108) begin
                check("never_lock_fail", bus.lock_fail, 1);
                check("never_lock_state", bus.state_dbg, 4);
            end
            step();
        end
        bus.pll_locked = 1'b1;
        repeat (40) step();
        check("fail_held_state", bus.state_dbg, 4);
        check("fail_held_pll_rst", bus.pll_rst, 1);
        $display("scenario never_locks: state=%0d lock_fail=%0d", bus.state_dbg, bus.lock_fail);

        // Scenario 5: recovery from FAIL via relock_req
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
        check("recover_lock_fail", bus.lock_fail, 0);
        check("recover_state", bus.state_dbg, 0);
        repeat (3) step();
        check("recover_pll_rst_high", bus.pll_rst, 1);
        step();
        check("recover_pll_rst_low", bus.pll_rst, 0);
        wait_state(3'd3, 60, n);
        check("recover_run_latency", n, 9);
        check("recover_loss_count", bus.loss_count, 255);
        $display("scenario recover_from_fail: ready=%0d loss_count=%0d", bus.ready, bus.loss_count);

        // Scenario 2: lock glitch during STABLE
        do_reset();
        wait_state(3'd1, 20, n);
        check("glitch_wait_entry", n, 4);
        saw_ready   = 0;
        saw_pll_rst = 0;
        bus.pll_locked = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.ready) saw_ready++;
            if (bus.pll_rst) saw_pll_rst++;
        end
        check("glitch_in_stable", bus.state_dbg, 2);
        bus.pll_locked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.ready) saw_ready++;
            if (bus.pll_rst) saw_pll_rst++;
        end
        check("glitch_back_to_wait", bus.state_dbg, 1);
        bus.pll_locked = 1'b1;
        first_run = 0;
        for (int k = 1; k <= 30 && first_run == 0; k++) begin
            step();
            if (bus.pll_rst) saw_pll_rst++;
            if (bus.ready) first_run = k;
        end
        check("glitch_no_early_ready", saw_ready, 0);
        check("glitch_no_pll_rst", saw_pll_rst, 0);
        check("glitch_run_latency", first_run, 11);
        $display("scenario lock_glitch: run after %0d cycles", first_run);

        // Scenario 6: rst mid-STABLE, then relock_req coinciding with a RUN loss
        do_reset();
        bus.pll_locked = 1'b1;
        wait_state(3'd3, 60, n);
        for (int i = 0; i < 3; i++) begin
            bus.pll_locked = 1'b0;
            wait_state(3'd0, 10, n);
            bus.pll_locked = 1'b1;
            if (i < 2) wait_state(3'd3, 60, n);
            else wait_state(3'd2, 60, n);
        end
        check("midrst_pre_state", bus.state_dbg, 2);
        check("midrst_pre_loss", bus.loss_count, 3);
        rst = 1'b1;
        step();
        check("midrst_pll_rst", bus.pll_rst, 1);
        check("midrst_sys_rst", bus.sys_rst, 1);
        check("midrst_ready", bus.ready, 0);
        check("midrst_loss", bus.loss_count, 0);
        check("midrst_state", bus.state_dbg, 0);
        rst = 1'b0;
        wait_state(3'd3, 60, n);
        check("coincide_reach_run", bus.ready, 1);
        bus.pll_locked = 1'b0;
        step();
        step();
        bus.relock_req = 1'b1;
        step();
        bus.relock_req = 1'b0;
        check("coincide_loss_count", bus.loss_count, 0);
        check("coincide_state", bus.state_dbg, 0);
        check("coincide_pll_rst", bus.pll_rst, 1);
        $display("scenario reset_and_coincide: loss_count=%0d", bus.loss_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
